// File: rtl/compressor_pkg.sv
// Shared types and sizing for the zero-run activation compressor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package compressor_pkg;

  // Memory word width in bytes; each 16-bit token occupies two bytes.
  localparam int MEM_BANDWIDTH = 8;
  localparam int WORD_W        = MEM_BANDWIDTH * 8;
  localparam int TOK_W         = 16;
  localparam int SLOTS         = MEM_BANDWIDTH / 2;
  localparam int SLOT_IDX_W    = $clog2(SLOTS + 1);

  // A token stands for zero_run zeros followed by one value byte.
  typedef struct packed {
    logic [7:0] zero_run;
    logic [7:0] value;
  } compress_token_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } compressor_state_t;

endpackage

// File: rtl/compressor_if.sv
// Activation stream in, packed memory words out.
// Latency: n/a (signal bundle).
// Backpressure: compressor_ready on the stream side, mem_req/mem_ack on the memory side.
interface compressor_if;
  import compressor_pkg::*;

  logic              ofmap_valid;
  logic [7:0]        ofmap_data;
  logic              ofmap_last;
  logic              compressor_ready;
  logic              mem_req;
  logic [WORD_W-1:0] mem_data;
  logic              mem_ack;

  // The compressor side.
  modport slave (
    input  ofmap_valid, ofmap_data, ofmap_last, mem_ack,
    output compressor_ready, mem_req, mem_data
  );

  // The producer/memory side.
  modport master (
    output ofmap_valid, ofmap_data, ofmap_last, mem_ack,
    input  compressor_ready, mem_req, mem_data
  );

endinterface

// File: rtl/compressor_packer.sv
// Packs tokens into memory words (slot 0 first), pads on flush, holds one word for the memory handshake.
// Latency: a full word reaches mem_req one edge after its last slot is written.
// Backpressure: stall when both assembly word and output buffer are full; stall never depends on mem_ack.
module compressor_packer
  import compressor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              tok_vld,
  input  compress_token_t   tok,
  input  logic              flush,
  output logic              stall,
  output logic              idle,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_data,
  input  logic              mem_ack
);

  logic [SLOT_IDX_W-1:0] slot_q;
  logic [WORD_W-1:0]     asm_q;
  logic [WORD_W-1:0]     buf_q;
  logic                  buf_full_q;
  logic                  asm_full;
  logic                  move;

  assign asm_full = (slot_q == SLOT_IDX_W'(SLOTS));
  // The buffer can take the assembly word when empty or emptying this edge.
  assign move     = asm_full & (~buf_full_q | mem_ack);
  assign stall    = asm_full & buf_full_q;
  assign idle     = (slot_q == '0) & ~buf_full_q;
  assign mem_req  = buf_full_q;
  assign mem_data = buf_q;

  // Output buffer: loaded from the assembly word, released on ack.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else if (move) begin
      buf_q      <= asm_q;
      buf_full_q <= 1'b1;
    end else if (mem_ack && buf_full_q) begin
      buf_full_q <= 1'b0;
    end
  end

  // Assembly word: unused slots stay zero, so padding only advances the slot index.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      asm_q  <= '0;
      slot_q <= '0;
    end else if (move) begin
      asm_q  <= tok_vld ? WORD_W'(tok) : '0;
      slot_q <= tok_vld ? SLOT_IDX_W'(1) : '0;
    end else if (tok_vld) begin
      // Upstream only issues a token here when the assembly word has room.
      asm_q[32'(slot_q)*TOK_W +: TOK_W] <= tok;
      slot_q                            <= slot_q + SLOT_IDX_W'(1);
    end else if (flush && slot_q != '0) begin
      slot_q <= SLOT_IDX_W'(SLOTS);
    end
  end

endmodule

// File: rtl/compressor.sv
// Zero-run-length compressor: activations -> {run,value} tokens -> packed memory words; COMPRESSOR_STATS_EN adds zero_count.
// Latency: a token is formed on the accepting edge; its word appears once the word fills or the layer flushes.
// Backpressure: compressor_ready drops while assembly word and output buffer are both full.
module compressor
  import compressor_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  compressor_if.slave  bus,
  output logic         done,
  output logic [23:0]  token_count,
  output logic [23:0]  zero_count
);

  compressor_state_t state_q, state_d;
  logic [7:0]        run_q;
  logic [23:0]       token_cnt_q;
  logic              accept;
  logic              is_zero;
  logic              tok_vld;
  compress_token_t   tok;
  logic              clear;
  logic              flush;
  logic              stall;
  logic              pk_idle;

  assign bus.compressor_ready = (state_q == RUN) & ~stall;
  assign accept  = bus.ofmap_valid & bus.compressor_ready;
  assign is_zero = (bus.ofmap_data == 8'h00);
  // A full run of 255 plus this zero is emitted as {255, 0x00}.
  assign tok_vld = accept & (bus.ofmap_last | ~is_zero | (run_q == 8'hFF));
  assign tok     = '{zero_run: run_q, value: bus.ofmap_data};
  assign token_count = token_cnt_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and control strobes.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    flush   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept && bus.ofmap_last) state_d = FLUSH;
      end
      FLUSH: begin
        flush = 1'b1;
        if (pk_idle) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-run counter: cleared by every emitted token.
  always_ff @(posedge clk) begin
    if (rst || clear)         run_q <= '0;
    else if (tok_vld)         run_q <= '0;
    else if (accept)          run_q <= run_q + 8'd1;
  end

  // Token counter, saturating; holds after the layer until the next start.
  always_ff @(posedge clk) begin
    if (rst || clear)                        token_cnt_q <= '0;
    else if (tok_vld && token_cnt_q != '1)   token_cnt_q <= token_cnt_q + 24'd1;
  end

`ifdef COMPRESSOR_STATS_EN
  logic [23:0] zero_cnt_q;

  // Zero activation counter, saturating.
  always_ff @(posedge clk) begin
    if (rst || clear)                                  zero_cnt_q <= '0;
    else if (accept && is_zero && zero_cnt_q != '1)    zero_cnt_q <= zero_cnt_q + 24'd1;
  end

  assign zero_count = zero_cnt_q;
`else
  assign zero_count = '0;
`endif

  compressor_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .tok_vld  (tok_vld),
    .tok      (tok),
    .flush    (flush),
    .stall    (stall),
    .idle     (pk_idle),
    .mem_req  (bus.mem_req),
    .mem_data (bus.mem_data),
    .mem_ack  (bus.mem_ack)
  );

endmodule

// File: tb/tb_compressor.sv
// Scoreboard bench for compressor: directed layers, expected words queued at stimulus time.
// Latency: n/a.
// Backpressure: exercised by holding mem_ack low.
module tb_compressor;
  import compressor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [23:0] token_count;
  logic [23:0] zero_count;

  compressor_if bus ();

  compressor dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .done        (done),
    .token_count (token_count),
    .zero_count  (zero_count)
  );

  always #5 clk = ~clk;

  int                tests = 0;
  int                fails = 0;
  int                done_cnt = 0;
  logic [WORD_W-1:0] exp_q[$];
  bit                pend = 1'b0;
  logic [WORD_W-1:0] pend_dat = '0;

`ifdef COMPRESSOR_STATS_EN
  localparam logic [23:0] Z300 = 24'd300;
  localparam logic [23:0] Z2   = 24'd2;
`else
  localparam logic [23:0] Z300 = 24'd0;
  localparam logic [23:0] Z2   = 24'd0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every acknowledged word against the queue and checks held data stays put.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (pend && bus.mem_req) check("mem_data_hold", bus.mem_data, pend_dat);
    if (bus.mem_req && bus.mem_ack) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %h expected none", bus.mem_data);
      end else begin
        check("word", bus.mem_data, exp_q.pop_front());
      end
    end
    pend     = bus.mem_req && !bus.mem_ack;
    pend_dat = bus.mem_data;
  end

  task automatic start_layer();
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit l);
    int n = 0;
    bus.ofmap_valid = 1'b1;
    bus.ofmap_data  = d;
    bus.ofmap_last  = l;
    @(negedge clk);
    while (!bus.compressor_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.compressor_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk); #1;
    bus.ofmap_valid = 1'b0;
    bus.ofmap_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_done_timeout: got done=0 expected done=1", name);
    end
    repeat (2) @(negedge clk);
    check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.ofmap_valid = 1'b0;
    bus.ofmap_data  = '0;
    bus.ofmap_last  = 1'b0;
    bus.mem_ack     = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_mem_data", bus.mem_data, 64'd0);
    check("rst_ready", 64'(bus.compressor_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_token_count", 64'(token_count), 64'd0);
    check("rst_zero_count", 64'(zero_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Layer 1: 5,0,0,7,3(last)
    exp_q.push_back(64'h0000_0003_0207_0005);
    start_layer();
    send(8'd5, 1'b0);
    send(8'd0, 1'b0);
    send(8'd0, 1'b0);
    send(8'd7, 1'b0);
    send(8'd3, 1'b1);
    wait_done("l1");
    check("l1_token_count", 64'(token_count), 64'd3);
    check("l1_idle_ready", 64'(bus.compressor_ready), 64'd0);

    // Layer 2: 300 zeros then 9(last)
    exp_q.push_back(64'h0000_0000_2C09_FF00);
    start_layer();
    for (int i = 0; i < 300; i++) send(8'd0, 1'b0);
    send(8'd9, 1'b1);
    wait_done("l2");
    check("l2_token_count", 64'(token_count), 64'd2);
    check("l2_zero_count", 64'(zero_count), 64'(Z300));

    // Layer 3: 1,0,0(last)
    exp_q.push_back(64'h0000_0000_0100_0001);
    start_layer();
    send(8'd1, 1'b0);
    send(8'd0, 1'b0);
    send(8'd0, 1'b1);
    wait_done("l3");
    check("l3_token_count", 64'(token_count), 64'd2);
    check("l3_zero_count", 64'(zero_count), 64'(Z2));

    // Layer 4: 12 nonzero beats against a stalled memory
    bus.mem_ack = 1'b0;
    exp_q.push_back(64'h0004_0003_0002_0001);
    exp_q.push_back(64'h0008_0007_0006_0005);
    exp_q.push_back(64'h000C_000B_000A_0009);
    start_layer();
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    repeat (3) @(negedge clk);
    check("l4_ready_stalled", 64'(bus.compressor_ready), 64'd0);
    check("l4_mem_req_held", 64'(bus.mem_req), 64'd1);
    @(posedge clk); #1;
    bus.mem_ack = 1'b1;
    for (int i = 9; i <= 12; i++) send(8'(i), (i == 12));
    wait_done("l4");
    check("l4_token_count", 64'(token_count), 64'd12);

    // Layer 5: reset mid-layer with a word pending, then a clean layer
    bus.mem_ack = 1'b0;
    start_layer();
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    @(negedge clk);
    check("l5_mem_req_before_rst", 64'(bus.mem_req), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("l5_mem_req_after_rst", 64'(bus.mem_req), 64'd0);
    check("l5_ready_after_rst", 64'(bus.compressor_ready), 64'd0);
    check("l5_token_count_after_rst", 64'(token_count), 64'd0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b1;
    exp_q.push_back(64'h0000_0000_0000_0004);
    start_layer();
    send(8'd4, 1'b1);
    wait_done("l5");
    check("l5_token_count", 64'(token_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/compressor.md
COMPRESSOR -- requirements
Module: compressor

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle pulse that begins a layer; honoured only in IDLE.
REQ-004 SHALL have port ofmap_valid  input  1  activation beat valid.
REQ-005 SHALL have port ofmap_data  input  8  activation value.
REQ-006 SHALL have port ofmap_last  input  1  final beat of the layer, qualified by ofmap_valid.
REQ-007 SHALL have port compressor_ready  output  1  beat accepted when ofmap_valid & compressor_ready.
REQ-008 SHALL have port mem_req  output  1  mem_data holds a valid word.
REQ-009 SHALL have port mem_data  output  MEM_BANDWIDTH*8  packed token word.
REQ-010 SHALL have port mem_ack  input  1  memory accepts the word on the edge where mem_req & mem_ack.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last word is acknowledged.
REQ-012 SHALL have port token_count  output  24  tokens emitted in the current/last layer.
REQ-013 SHALL have port zero_count  output  24  zero activations seen (see Configuration).

Function
REQ-014 Token SHALL be 16 bits {zero_run[15:8], value[7:0]}, meaning zero_run zeros followed by value.
REQ-015 Accepted nonzero beat SHALL emit {run, data}, then clear run.
REQ-016 Accepted zero beat with run<255 and not last SHALL increment run and emit nothing.
REQ-017 Accepted zero beat with run==255 and not last SHALL emit {255, 0x00} (256 zeros), then clear run.
REQ-018 Accepted last beat SHALL always emit {run, data}, whether data is zero or not.
REQ-019 Tokens SHALL pack into W=MEM_BANDWIDTH/2 slots, slot k at bits [16k+15:16k], filled from slot 0 upward.
REQ-020 There SHALL be an assembly register plus a one-word output buffer; mem_req is high while the output buffer is full.
REQ-021 A full assembly word SHALL transfer to the output buffer on the edge where the buffer is empty or being acked; a new token may enter slot 0 on the same edge.
REQ-022 compressor_ready SHALL be (state==RUN) & !(assembly_full & outbuf_full).
REQ-023 compressor_ready SHALL have no combinational path from mem_ack.
REQ-024 mem_data SHALL stay stable while mem_req is high and not acked.
REQ-025 FSM states SHALL be IDLE, RUN, FLUSH, DONE.
REQ-026 FSM transitions: IDLE->RUN on start, clearing run, slots, token_count and zero_count.
REQ-027 FSM transitions: RUN->FLUSH on the accepted last beat.
REQ-028 FSM transitions: FLUSH pads a partial word with 0x0000 slots, moves it to the buffer, then waits for the buffer to empty.
REQ-029 FSM transitions: FLUSH->DONE after the buffer empties; DONE->IDLE after one cycle with done=1.
REQ-030 start outside IDLE SHALL be ignored; ofmap_valid outside RUN SHALL be ignored.
REQ-031 token_count SHALL increment per emitted token, saturate at 2^24-1, and hold after DONE until the next start.

Reset
REQ-032 On rst: state=IDLE; run, slot index, assembly and buffer cleared; mem_req=0; mem_data=0; compressor_ready=0; done=0; token_count=0; zero_count=0.
REQ-033 rst mid-layer SHALL abandon all pending tokens and words, with mem_req low from the next cycle; a subsequent start begins a clean layer.

Configuration
REQ-034 With COMPRESSOR_STATS_EN defined, zero_count SHALL count every accepted zero beat, saturating at 2^24-1.
REQ-035 Without COMPRESSOR_STATS_EN, zero_count SHALL be tied to 0 and no counter logic is generated.

Structure
REQ-036 Shared package SHALL hold the COMPRESS_TOKEN struct {zero_run, value}, the COMPRESSOR_STATE enum, and the existing MEM_BANDWIDTH definition.
REQ-037 Slot assembly, padding, output buffer and mem handshake SHALL live in sub-module compressor_packer.
REQ-038 Token generation and the FSM SHALL live in compressor.

Verification (bench built with MEM_BANDWIDTH=8, W=4)
REQ-039 Beats 5,0,0,7,3(last) -> one word, slots 0x0005,0x0207,0x0003,0x0000; token_count=3; done pulses once.
REQ-040 300 zeros then 9(last) -> tokens 0xFF00, 0x2C09; with COMPRESSOR_STATS_EN, zero_count=300.
REQ-041 Beats 1,0,0(last) -> tokens 0x0001, 0x0100; token_count=2.
REQ-042 12 nonzero beats with mem_ack held 0 -> ready drops after 8 accepted; releasing ack delivers 3 words in order with none lost or duplicated.
REQ-043 rst asserted during RUN with mem_req=1 -> next cycle mem_req=0, ready=0, state IDLE; the next start plus stream 4(last) yields a single word 0x0004 in slot 0.
